fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
- Parametrised fetch front end: owns the PC and issues requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs in a DEPTH-entry queue feeding decode via valid/ready.
- Supports multiple outstanding memory requests, decode backpressure without refetch, and branch redirect that flushes the queue and discards stale in-flight responses.
- Sits between the PC/branch logic and the IF/ID boundary.

Parameters:
- XLEN, 32, address/PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >=2; also bounds outstanding requests.
- RESET_PC, 0, PC value after reset.
- PC_STEP, 4, PC increment per accepted request.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  XLEN  request address (= pc_q).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid; in order, cannot be back-pressured.
- imem_rsp_data  in  ILEN  response instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  restart address.
- id_valid  out  1  head entry holds an instruction.
- id_ready  in  1  decode consumes head.
- id_instr  out  ILEN  head instruction.
- id_pc  out  XLEN  head PC.
- occupancy  out  $clog2(DEPTH)+1  reserved entries (filled + awaiting response).
- rsp_err  out  1  sticky: response received with nothing outstanding.

Behaviour:
- Reset (async): pc_q=RESET_PC; queue pointers, occupancy, fill pointer and drop_cnt cleared; id_valid=0, id_instr=0, id_pc=0, imem_req_valid=0, rsp_err=0.
- Entry allocation: on request handshake, entry at tail is reserved with pc_q and marked unfilled; pc_q += PC_STEP (wraps modulo 2^XLEN); tail++.
- imem_req_valid = !redirect_valid && (occupancy + drop_cnt) < DEPTH. Outstanding responses never exceed DEPTH.
- Response: if drop_cnt>0, data discarded and drop_cnt--. Otherwise, if an unfilled reserved entry exists, data is written at the fill pointer and the fill pointer advances. Otherwise the response is ignored and rsp_err is set (sticky until reset).
- The earliest legal response is the cycle after the request is accepted. A response in the same cycle as acceptance of its own request is illegal.
- Decode: id_valid=1 when head is reserved and filled; id_instr/id_pc are driven from head. Pop on id_valid && id_ready; head++. Head is held stable while id_ready=0.
- Same-cycle request + response + pop are all legal; occupancy = occupancy + req_fire - pop.
- Redirect (highest priority): at the clock edge, all entries are cleared (occupancy=0, pointers reset); pc_q=redirect_pc. drop_cnt_next = drop_cnt + unfilled_reserved - (imem_rsp_valid ? 1 : 0), where the response in the redirect cycle is dropped. A pop in the redirect cycle is accepted by decode but has no further effect. No request is issued during the redirect cycle.
- Latency, redirect at cycle 0 with 1-cycle memory and no pending drops: request at redirect_pc in cycle 1, response in cycle 2, id_valid=1 in cycle 3.
- Steady state with 1-cycle memory and id_ready=1: one instruction per cycle.
- Full queue (occupancy=DEPTH): imem_req_valid=0 until a pop occurs. No instruction is ever lost or duplicated.
- Reset mid-operation: in-flight responses arriving after reset deassertion set rsp_err. The system resets memory together with this unit.

Test Plan:
- Reset, RESET_PC=0x100, 1-cycle memory, id_ready=1 -> requests 0x100, 0x104, 0x108...; id_pc sequence is identical; first id_valid 2 cycles after first request; 1 instruction/cycle thereafter.
- id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued, occupancy=4, imem_req_valid=0; releasing id_ready delivers 0x100..0x10C in order with no gaps or duplicates.
- 3-cycle memory latency with 3 requests in flight, redirect to 0x400 -> 3 stale responses dropped (drop_cnt 3→0); first id_pc=0x400; none of the stale instructions appear.
- Redirect in the same cycle as a response and a pop -> the response is dropped; drop_cnt = unfilled-1; queue is empty next cycle; fetch restarts at redirect_pc.
- imem_req_ready toggled randomly -> imem_req_addr is held while valid && !ready; no PC skipped.
- Response with occupancy=0 and drop_cnt=0 -> rsp_err=1 and stays set; queue is unchanged.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the PC, issues in-order instruction memory requests and
// buffers returned instructions with their PCs for decode; redirects flush and drop stale data.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [ILEN-1:0]          imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [ILEN-1:0]          id_instr,
    output logic [XLEN-1:0]          id_pc,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_pc_q;
    logic [CW-1:0]   r_head;
    logic [CW-1:0]   r_fill;
    logic [CW-1:0]   r_tail;
    logic [CW-1:0]   r_drop_cnt;
    logic            r_rsp_err;
    logic [ILEN-1:0] r_instr [DEPTH];
    logic [XLEN-1:0] r_pc    [DEPTH];

    logic [CW-1:0]   w_occ;
    logic [CW-1:0]   w_unfilled;
    logic [CW:0]     w_budget;
    logic            w_req_fire;
    logic            w_pop;
    logic            w_rsp_drop;
    logic            w_rsp_fill;
    logic            w_rsp_stray;
    logic            w_rsp_consumed;
    logic [CW-1:0]   w_drop_redirect;

    // Pointers carry one wrap bit: head..fill are filled, fill..tail await a response.
    assign w_occ       = r_tail - r_head;
    assign w_unfilled  = r_tail - r_fill;
    assign w_budget    = {1'b0, w_occ} + {1'b0, r_drop_cnt};

    assign imem_req_valid = !reset && !redirect_valid && (w_budget < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_pc_q;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_rsp_drop     = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_fill     = imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0);
    assign w_rsp_stray    = imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled == '0);
    assign w_rsp_consumed = w_rsp_drop || w_rsp_fill;

    // Every response still owed to us becomes a drop; the one arriving now is already gone.
    assign w_drop_redirect = r_drop_cnt + w_unfilled - CW'(w_rsp_consumed);

    assign id_valid  = (r_fill != r_head);
    assign id_instr  = r_instr[r_head[AW-1:0]];
    assign id_pc     = r_pc[r_head[AW-1:0]];
    assign w_pop     = id_valid && id_ready;
    assign occupancy = w_occ;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_q     <= RESET_PC;
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_drop_cnt <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_rsp_stray) begin
                r_rsp_err <= 1'b1;
            end
            if (redirect_valid) begin
                r_pc_q     <= redirect_pc;
                r_head     <= '0;
                r_fill     <= '0;
                r_tail     <= '0;
                r_drop_cnt <= w_drop_redirect;
            end else begin
                if (w_req_fire) begin
                    r_pc_q <= r_pc_q + PC_STEP;
                    r_tail <= r_tail + CW'(1);
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_rsp_fill) begin
                    r_fill <= r_fill + CW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (!redirect_valid) begin
            if (w_req_fire) begin
                r_pc[r_tail[AW-1:0]] <= r_pc_q;
            end
            if (w_rsp_fill) begin
                r_instr[r_fill[AW-1:0]] <= imem_rsp_data;
            end
        end
    end

endmodule
